// File: rtl/acc_cpu_pkg.sv
// Shared definitions for the multi-cycle accumulator CPU:
// opcode values, FSM states and the opcode field width.
package acc_cpu_pkg;

  localparam int OPC_W = 4;

  localparam logic [OPC_W-1:0] OP_NOP = 4'd0;
  localparam logic [OPC_W-1:0] OP_LDA = 4'd1;
  localparam logic [OPC_W-1:0] OP_ADD = 4'd2;
  localparam logic [OPC_W-1:0] OP_SUB = 4'd3;
  localparam logic [OPC_W-1:0] OP_AND = 4'd4;
  localparam logic [OPC_W-1:0] OP_OR  = 4'd5;
  localparam logic [OPC_W-1:0] OP_XOR = 4'd6;
  localparam logic [OPC_W-1:0] OP_STA = 4'd7;
  localparam logic [OPC_W-1:0] OP_OUT = 4'd8;
  localparam logic [OPC_W-1:0] OP_JMP = 4'd9;
  localparam logic [OPC_W-1:0] OP_JZ  = 4'd10;
  localparam logic [OPC_W-1:0] OP_JC  = 4'd11;
  localparam logic [OPC_W-1:0] OP_HLT = 4'd15;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_HALT
  } state_e;

endpackage

// File: rtl/acc_cpu_multicycle_if.sv
// Host load port: one write strobe shared by
// instruction and data memory.
interface acc_cpu_multicycle_if #(
  parameter int DATA_W  = 8,
  parameter int IMEM_AW = 5
);

  logic [DATA_W-1:0]  cpu_input;
  logic [IMEM_AW-1:0] load_address;
  logic               load;
  logic               is_instruction;

  modport master (
    output cpu_input,
    output load_address,
    output load,
    output is_instruction
  );

  modport slave (
    input cpu_input,
    input load_address,
    input load,
    input is_instruction
  );

endinterface

// File: rtl/acc_cpu_alu.sv
// Combinational ALU: result, carry/borrow, zero
// and which architectural registers to update.
module acc_cpu_alu
  import acc_cpu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] i_acc,
  input  logic [DATA_W-1:0] i_opnd,
  input  logic [OPC_W-1:0]  i_opc,
  output logic [DATA_W-1:0] o_result,
  output logic              o_carry,
  output logic              o_zero,
  output logic              o_wr_acc,
  output logic              o_wr_c
);

  logic [DATA_W:0] w_ext;

  always_comb begin
    w_ext    = '0;
    o_result = i_acc;
    o_carry  = 1'b0;
    o_wr_acc = 1'b0;
    o_wr_c   = 1'b0;
    unique case (i_opc)
      OP_LDA: begin
        o_result = i_opnd;
        o_wr_acc = 1'b1;
      end
      OP_ADD: begin
        w_ext    = {1'b0, i_acc} + {1'b0, i_opnd};
        o_result = w_ext[DATA_W-1:0];
        o_carry  = w_ext[DATA_W];
        o_wr_acc = 1'b1;
        o_wr_c   = 1'b1;
      end
      // top bit of the widened difference is the borrow
      OP_SUB: begin
        w_ext    = {1'b0, i_acc} - {1'b0, i_opnd};
        o_result = w_ext[DATA_W-1:0];
        o_carry  = w_ext[DATA_W];
        o_wr_acc = 1'b1;
        o_wr_c   = 1'b1;
      end
      OP_AND: begin
        o_result = i_acc & i_opnd;
        o_wr_acc = 1'b1;
      end
      OP_OR: begin
        o_result = i_acc | i_opnd;
        o_wr_acc = 1'b1;
      end
      OP_XOR: begin
        o_result = i_acc ^ i_opnd;
        o_wr_acc = 1'b1;
      end
      default: ;
    endcase
    o_zero = (o_result == '0);
  end

endmodule

// File: rtl/acc_cpu_multicycle.sv
// Multi-cycle accumulator CPU: FETCH/DECODE/EXEC FSM,
// registered instruction/data memories, Z/C flags.
module acc_cpu_multicycle
  import acc_cpu_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int IMEM_AW = 5,
  parameter int DMEM_AW = 4
) (
  input  logic                clk,
  input  logic                reset,
  acc_cpu_multicycle_if.slave ld_bus,
  input  logic                start,
  output logic                busy,
  output logic                halted,
  output logic                out_valid,
  output logic [DMEM_AW-1:0]  out_index,
  output logic [DATA_W-1:0]   output_value
);

  localparam int IW = OPC_W + DMEM_AW;

  state_e r_state;
  state_e w_next;

  logic [IW-1:0]      r_imem [2**IMEM_AW];
  logic [DATA_W-1:0]  r_dmem [2**DMEM_AW];

  logic [IMEM_AW-1:0] r_pc;
  logic [IW-1:0]      r_ir;
  logic [DATA_W-1:0]  r_opnd;
  logic [DATA_W-1:0]  r_acc;
  logic               r_z;
  logic               r_c;
  logic               r_out_valid;
  logic [DMEM_AW-1:0] r_out_idx;
  logic [DATA_W-1:0]  r_out_val;

  logic [OPC_W-1:0]   w_opc;
  logic [DMEM_AW-1:0] w_op;
  logic [DATA_W-1:0]  w_res;
  logic               w_carry;
  logic               w_zero;
  logic               w_wr_acc;
  logic               w_wr_c;
  logic               w_ready;
  logic               w_go;
  logic               w_exec;
  logic               w_take;

  assign w_opc   = r_ir[IW-1:DMEM_AW];
  assign w_op    = r_ir[DMEM_AW-1:0];
  assign w_ready = (r_state == S_IDLE) ||
                   (r_state == S_HALT);
  assign w_go    = w_ready && start;
  assign w_exec  = (r_state == S_EXEC);
  assign w_take  = (w_opc == OP_JMP) ||
                   ((w_opc == OP_JZ) && r_z) ||
                   ((w_opc == OP_JC) && r_c);

  acc_cpu_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .i_acc    (r_acc),
    .i_opnd   (r_opnd),
    .i_opc    (w_opc),
    .o_result (w_res),
    .o_carry  (w_carry),
    .o_zero   (w_zero),
    .o_wr_acc (w_wr_acc),
    .o_wr_c   (w_wr_c)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE,
      S_HALT:   if (start) w_next = S_FETCH;
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: w_next = S_EXEC;
      S_EXEC:   w_next = (w_opc == OP_HLT) ? S_HALT
                                           : S_FETCH;
      default:  w_next = S_IDLE;
    endcase
  end

  // Memories carry no reset so they map onto block RAM.
  always_ff @(posedge clk) begin
    if (w_ready && ld_bus.load) begin
      if (ld_bus.is_instruction)
        r_imem[ld_bus.load_address] <=
          ld_bus.cpu_input[IW-1:0];
      else
        r_dmem[ld_bus.load_address[DMEM_AW-1:0]] <=
          ld_bus.cpu_input;
    end
    if (w_exec && (w_opc == OP_STA))
      r_dmem[w_op] <= r_acc;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc        <= '0;
      r_ir        <= '0;
      r_opnd      <= '0;
      r_acc       <= '0;
      r_z         <= 1'b0;
      r_c         <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_idx   <= '0;
      r_out_val   <= '0;
    end else begin
      r_out_valid <= 1'b0;
      if (w_go) begin
        r_pc  <= '0;
        r_acc <= '0;
        r_z   <= 1'b0;
        r_c   <= 1'b0;
      end
      if (r_state == S_FETCH)
        r_ir <= r_imem[r_pc];
      if (r_state == S_DECODE)
        r_opnd <= r_dmem[w_op];
      if (w_exec) begin
        r_pc <= w_take ? IMEM_AW'(w_op)
                       : r_pc + 1'b1;
        if (w_wr_acc) begin
          r_acc <= w_res;
          r_z   <= w_zero;
        end
        if (w_wr_c) r_c <= w_carry;
        if (w_opc == OP_OUT) begin
          r_out_valid <= 1'b1;
          r_out_idx   <= w_op;
          r_out_val   <= r_acc;
        end
      end
    end
  end

  assign busy         = (r_state == S_FETCH)  ||
                        (r_state == S_DECODE) ||
                        (r_state == S_EXEC);
  assign halted       = (r_state == S_HALT);
  assign out_valid    = r_out_valid;
  assign out_index    = r_out_idx;
  assign output_value = r_out_val;

endmodule

// File: tb/tb_acc_cpu_multicycle.sv
// Bench for acc_cpu_multicycle: instruction-level model
// with a fixed 3-cycle timing rule, plus directed programs.
module tb_acc_cpu_multicycle;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       busy;
  logic       halted;
  logic       out_valid;
  logic [3:0] out_index;
  logic [7:0] output_value;

  acc_cpu_multicycle_if #(.DATA_W(8), .IMEM_AW(5)) bus ();

  acc_cpu_multicycle #(
    .DATA_W  (8),
    .IMEM_AW (5),
    .DMEM_AW (4)
  ) dut (
    .clk          (clk),
    .reset        (rst_n),
    .ld_bus       (bus),
    .start        (start),
    .busy         (busy),
    .halted       (halted),
    .out_valid    (out_valid),
    .out_index    (out_index),
    .output_value (output_value)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;
  int cyc    = 0;
  bit chk_en = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  nm, act, exp);
  endtask

  always begin
    @(posedge clk);
    cyc++;
  end

  // Instruction-level model: whole instruction applied
  // three edges after the previous one (or after start).
  logic [7:0] mi [32];
  logic [7:0] md [16];
  int m_pc, m_acc, m_rel;
  bit m_z, m_c, m_run, m_halt;
  bit e_ov;
  int e_oi, e_val;

  function automatic void m_step();
    int ins, opc, op, v, t;
    ins  = int'(mi[m_pc]);
    opc  = ins / 16;
    op   = ins % 16;
    v    = int'(md[op]);
    m_pc = (m_pc + 1) % 32;
    case (opc)
      1:  begin m_acc = v; m_z = (m_acc == 0); end
      2:  begin
            t     = m_acc + v;
            m_c   = (t > 255);
            m_acc = t % 256;
            m_z   = (m_acc == 0);
          end
      3:  begin
            m_c   = (m_acc < v);
            m_acc = (m_acc - v + 256) % 256;
            m_z   = (m_acc == 0);
          end
      4:  begin m_acc = m_acc & v; m_z = (m_acc == 0); end
      5:  begin m_acc = m_acc | v; m_z = (m_acc == 0); end
      6:  begin m_acc = m_acc ^ v; m_z = (m_acc == 0); end
      7:  md[op] = 8'(m_acc);
      8:  begin e_ov = 1; e_oi = op; e_val = m_acc; end
      9:  m_pc = op;
      10: if (m_z) m_pc = op;
      11: if (m_c) m_pc = op;
      15: begin m_run = 0; m_halt = 1; end
      default: ;
    endcase
  endfunction

  always begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_run = 0; m_halt = 0;
      e_ov = 0; e_oi = 0; e_val = 0;
    end else begin
      e_ov = 0;
      if (m_run) begin
        m_rel++;
        if (m_rel == 3) begin
          m_rel = 0;
          m_step();
        end
      end else begin
        if (bus.load) begin
          if (bus.is_instruction)
            mi[bus.load_address] = bus.cpu_input;
          else
            md[bus.load_address[3:0]] = bus.cpu_input;
        end
        if (start) begin
          m_run = 1; m_halt = 0; m_rel = 0;
          m_pc = 0; m_acc = 0; m_z = 0; m_c = 0;
        end
      end
    end
  end

  always begin
    @(negedge clk);
    if (chk_en && rst_n) begin
      chk("busy", busy, m_run);
      chk("halted", halted, m_halt);
      chk("out_valid", out_valid, e_ov);
      chk("out_index", out_index, e_oi);
      chk("output_value", output_value, e_val);
    end
  end

  int npulse;
  int last_idx;
  int last_val;

  always begin
    @(negedge clk);
    if (rst_n && out_valid) begin
      npulse++;
      last_idx = out_index;
      last_val = output_value;
    end
  end

  int S, ch;

  task automatic ld(input bit isi, input int a,
                    input int d);
    bus.load           = 1'b1;
    bus.is_instruction = isi;
    bus.load_address   = a[4:0];
    bus.cpu_input      = d[7:0];
    @(negedge clk);
    bus.load = 1'b0;
  endtask

  task automatic go();
    npulse = 0;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    S     = cyc;
  endtask

  task automatic wait_halt(input int budget);
    int k;
    k = 0;
    while (!halted && k < budget) begin
      @(negedge clk);
      k++;
    end
    ch = cyc;
    chk("halt_timeout", halted, 1);
  endtask

  task automatic pin(input string t, input int hc,
                     input int np, input int idx,
                     input int val);
    chk({t, "_halt_cycle"}, ch - S, hc);
    chk({t, "_pulses"}, npulse, np);
    chk({t, "_index"}, last_idx, idx);
    chk({t, "_value"}, last_val, val);
  endtask

  task automatic reset_pulse();
    #2 rst_n = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    bus.load = 1'b0;
    bus.is_instruction = 1'b0;
    bus.load_address = '0;
    bus.cpu_input = '0;
    npulse = 0; last_idx = -1; last_val = -1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_halted", halted, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_value", output_value, 0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk_en = 1;

    for (int i = 0; i < 32; i++) ld(1, i, 'hF0);
    for (int i = 0; i < 16; i++) ld(0, i, 0);

    // LDA 0, ADD 1, OUT 2, HLT
    ld(0, 0, 5); ld(0, 1, 3);
    ld(1, 0, 'h10); ld(1, 1, 'h21);
    ld(1, 2, 'h82); ld(1, 3, 'hF0);
    go(); wait_halt(60);
    pin("add", 12, 1, 2, 8);

    // 0xFF+1 -> 0, C=1, Z=1, JZ taken to OUT 1
    ld(0, 0, 'hFF); ld(0, 1, 'h01);
    ld(1, 0, 'h10); ld(1, 1, 'h21);
    ld(1, 2, 'hA6); ld(1, 3, 'h80);
    ld(1, 4, 'hF0); ld(1, 5, 'h00);
    ld(1, 6, 'h81); ld(1, 7, 'hF0);
    go(); wait_halt(60);
    pin("carry", 15, 1, 1, 0);

    // 2-3 -> 0xFF, borrow; JZ not taken, JC taken
    ld(0, 2, 2); ld(0, 3, 3);
    ld(1, 0, 'h12); ld(1, 1, 'h33);
    ld(1, 2, 'hA7); ld(1, 3, 'hB5);
    ld(1, 4, 'hF0); ld(1, 5, 'h84);
    ld(1, 6, 'hF0); ld(1, 7, 'h8F);
    ld(1, 8, 'hF0);
    go(); wait_halt(60);
    pin("borrow", 18, 1, 4, 'hFF);

    // STA 9 then LDA 9; imem[0] loaded with start
    ld(0, 0, 7); ld(0, 1, 'h33); ld(0, 9, 0);
    ld(1, 1, 'h79); ld(1, 2, 'h11);
    ld(1, 3, 'h19); ld(1, 4, 'h80);
    ld(1, 5, 'hF0);
    npulse = 0;
    start = 1'b1;
    ld(1, 0, 'h10);
    start = 1'b0;
    S = cyc;
    wait_halt(60);
    pin("sta_lda", 18, 1, 0, 7);

    // load and start while busy must be ignored
    ld(0, 0, 'h11);
    ld(1, 0, 'h10); ld(1, 1, 'h20);
    ld(1, 2, 'h83); ld(1, 3, 'hF0);
    go();
    repeat (3) @(negedge clk);
    ld(1, 1, 'h85);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_halt(60);
    pin("busy_ign", 12, 1, 3, 'h22);
    go(); wait_halt(60);
    pin("rerun", 12, 1, 3, 'h22);

    // reset in DECODE, then endless NOP program
    for (int i = 0; i < 32; i++) ld(1, i, 'h00);
    go();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_busy", busy, 0);
    chk("mid_halted", halted, 0);
    chk("mid_out_valid", out_valid, 0);
    chk("mid_index", out_index, 0);
    chk("mid_value", output_value, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    go();
    repeat (110) @(negedge clk);
    chk("wrap_busy", busy, 1);
    chk("wrap_halted", halted, 0);

    // OUT at address 0 recurs after the PC wraps
    reset_pulse();
    ld(1, 0, 'h87);
    go();
    repeat (110) @(negedge clk);
    chk("wrap_pulses", npulse, 2);
    chk("wrap_index", last_idx, 7);
    chk("wrap_value", last_val, 0);

    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
